// File: rtl/mem_client_arbiter.sv
// SDRAM client front end: arbitrates port A (fetch) and port B (data), inserts refresh.
// Optional ARB_ROUND_ROBIN_EN alternates A/B priority; default build is fixed B over A.
module mem_client_arbiter #(
    parameter int unsigned REFRESH_CYCLES = 780
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [22:0] a_addr,
    output logic        a_ack,
    output logic        a_valid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [22:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_mask,
    output logic        b_ack,
    output logic        b_valid,
    output logic [31:0] b_rdata,
    output logic        mc_read_a,
    output logic        mc_read_b,
    output logic        mc_write,
    output logic        mc_refresh,
    output logic [22:0] mc_addr,
    output logic [31:0] mc_din,
    output logic [3:0]  mc_mask,
    input  logic [31:0] mc_dout_a,
    input  logic [31:0] mc_dout_b,
    input  logic        mc_busy,
    input  logic        mc_initialized,
    output logic        refresh_late
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
    } state_e;

    typedef enum logic [1:0] {
        CMD_REF, CMD_A, CMD_BRD, CMD_BWR
    } cmd_e;

    localparam logic [15:0] RELOAD = 16'(REFRESH_CYCLES - 1);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [15:0] timer_q, timer_d;
    logic        pend_q, pend_d;
    logic        late_q, late_d;
    logic        expire, can_go, want_ref, ref_clr, done;
    logic        grant_ref, grant_a, grant_b;

    logic        a_ack_q, a_ack_d, a_valid_q, a_valid_d;
    logic        b_ack_q, b_ack_d, b_valid_q, b_valid_d;
    logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic        rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic        wr_q, wr_d, ref_q, ref_d;
    logic [22:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [3:0]  mask_q, mask_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic        prio_a_q, prio_a_d;
`endif

    // Refresh timer and pending/late bookkeeping
    always_comb begin
        expire  = mc_initialized && (timer_q == 16'd0);
        timer_d = timer_q - 16'd1;
        if (!mc_initialized || timer_q == 16'd0) begin
            timer_d = RELOAD;
        end
        ref_clr = (state_q == ISSUE) && (cmd_q == CMD_REF);
        pend_d  = pend_q;
        if (ref_clr) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
        late_d = late_q | (expire & pend_q & ~ref_clr);
    end

    // A same-cycle expiry counts as pending so refresh beats a client
    always_comb begin
        can_go    = (state_q == IDLE) && mc_initialized && !mc_busy;
        want_ref  = pend_q | expire;
        grant_ref = can_go & want_ref;
`ifdef ARB_ROUND_ROBIN_EN
        grant_b   = can_go & ~want_ref & b_req & (~a_req | ~prio_a_q);
        grant_a   = can_go & ~want_ref & a_req & ~grant_b;
        prio_a_d  = prio_a_q;
        if (grant_a) begin
            prio_a_d = 1'b0;
        end
        if (grant_b) begin
            prio_a_d = 1'b1;
        end
`else
        grant_b   = can_go & ~want_ref & b_req;
        grant_a   = can_go & ~want_ref & a_req & ~b_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_REF;
            timer_q   <= RELOAD;
            pend_q    <= 1'b0;
            late_q    <= 1'b0;
            a_ack_q   <= 1'b0;
            a_valid_q <= 1'b0;
            a_rdata_q <= '0;
            b_ack_q   <= 1'b0;
            b_valid_q <= 1'b0;
            b_rdata_q <= '0;
            rd_a_q    <= 1'b0;
            rd_b_q    <= 1'b0;
            wr_q      <= 1'b0;
            ref_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            mask_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_a_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            late_q    <= late_d;
            a_ack_q   <= a_ack_d;
            a_valid_q <= a_valid_d;
            a_rdata_q <= a_rdata_d;
            b_ack_q   <= b_ack_d;
            b_valid_q <= b_valid_d;
            b_rdata_q <= b_rdata_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            wr_q      <= wr_d;
            ref_q     <= ref_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            mask_q    <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_a_q  <= prio_a_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (grant_ref | grant_a | grant_b) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (mc_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!mc_busy) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Strobes, acks and valids are computed one cycle early and registered
    always_comb begin
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        mask_d  = mask_q;
        rd_a_d  = grant_a;
        rd_b_d  = grant_b & ~b_we;
        wr_d    = grant_b & b_we;
        ref_d   = grant_ref;
        a_ack_d = grant_a;
        b_ack_d = grant_b;
        unique case (1'b1)
            grant_ref: begin
                cmd_d  = CMD_REF;
                addr_d = '0;
                din_d  = '0;
                mask_d = '0;
            end
            grant_a: begin
                cmd_d  = CMD_A;
                addr_d = a_addr;
                din_d  = '0;
                mask_d = '0;
            end
            grant_b: begin
                cmd_d  = b_we ? CMD_BWR : CMD_BRD;
                addr_d = b_addr;
                din_d  = b_wdata;
                mask_d = b_mask;
            end
            default: ;
        endcase
        done      = (state_q == WAIT_DONE) && !mc_busy;
        a_valid_d = done && (cmd_q == CMD_A);
        b_valid_d = done && (cmd_q == CMD_BRD || cmd_q == CMD_BWR);
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_valid_d) begin
            a_rdata_d = mc_dout_a;
        end
        if (done && cmd_q == CMD_BRD) begin
            b_rdata_d = mc_dout_b;
        end
    end

    assign a_ack        = a_ack_q;
    assign a_valid      = a_valid_q;
    assign a_rdata      = a_rdata_q;
    assign b_ack        = b_ack_q;
    assign b_valid      = b_valid_q;
    assign b_rdata      = b_rdata_q;
    assign mc_read_a    = rd_a_q;
    assign mc_read_b    = rd_b_q;
    assign mc_write     = wr_q;
    assign mc_refresh   = ref_q;
    assign mc_addr      = addr_q;
    assign mc_din       = din_q;
    assign mc_mask      = mask_q;
    assign refresh_late = late_q;

endmodule

// File: doc/mem_client_arbiter.md
# mem_client_arbiter

Client-side front end for the SDRAM memory controller. Arbitrates one read-only port (A, instruction fetch) and one read/write port (B, data), and inserts periodic auto-refresh. It drives the controller's single-cycle command strobes (`read_a`, `read_b`, `write`, `refresh`) and tracks its `busy` handshake to completion. Read data is returned to the requesting port with a one-cycle valid pulse.

## Interface
Parameters:
- `REFRESH_CYCLES`, default 780: `clk` cycles between refresh requests (1..65535).

Ports:
- `clk`  in  1  logic clock; same clock as the memory controller.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  port A read request; held with `a_addr` until `a_ack`.
- `a_addr`  in  23  port A word address.
- `a_ack`  out  1  one-cycle pulse: A request accepted.
- `a_valid`  out  1  one-cycle pulse: `a_rdata` valid.
- `a_rdata`  out  32  port A read data.
- `b_req`  in  1  port B request; held with `b_we`, `b_addr`, `b_wdata`, `b_mask` until `b_ack`.
- `b_we`  in  1  1 = write, 0 = read.
- `b_addr`  in  23  port B word address.
- `b_wdata`  in  32  port B write data.
- `b_mask`  in  4  port B byte mask, passed through to the controller.
- `b_ack`  out  1  one-cycle pulse: B request accepted.
- `b_valid`  out  1  one-cycle pulse: B read data valid, or B write completed.
- `b_rdata`  out  32  port B read data.
- `mc_read_a`, `mc_read_b`, `mc_write`, `mc_refresh`  out  1 each  controller command strobes.
- `mc_addr`  out  23  controller address.
- `mc_din`  out  32  controller write data.
- `mc_mask`  out  4  controller byte mask.
- `mc_dout_a`, `mc_dout_b`  in  32 each  controller read data.
- `mc_busy`  in  1  controller busy.
- `mc_initialized`  in  1  controller initialization done.
- `refresh_late`  out  1  sticky flag: a refresh period expired while the previous refresh was still pending.

## Operation
- State machine states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If `mc_initialized=1` and `mc_busy=0`, select a source in this order: pending refresh, then clients by the priority rule under Configuration.
  - Register the selected command and go to ISSUE.
  - Stay in IDLE if nothing is pending.
- ISSUE (exactly one cycle):
  - Exactly one `mc_*` strobe is high.
  - `mc_addr`, `mc_din` and `mc_mask` are driven from the captured request.
  - `a_ack` or `b_ack` pulses in this cycle for a client grant. Refresh produces no ack.
  - Next state is WAIT_BUSY.
- WAIT_BUSY: wait for `mc_busy=1`, then go to WAIT_DONE.
- WAIT_DONE: wait for `mc_busy=0`, then go to RESP.
- RESP (one cycle):
  - A read: capture `mc_dout_a` into `a_rdata`, pulse `a_valid`.
  - B read: capture `mc_dout_b` into `b_rdata`, pulse `b_valid`.
  - B write: pulse `b_valid`; `b_rdata` is unchanged.
  - Refresh: no pulse.
  - Next state is IDLE.
- Refresh timer:
  - 16-bit down-counter, held at `REFRESH_CYCLES-1` while `mc_initialized=0`.
  - On reaching 0: set `refresh_pending` and reload.
  - If it reaches 0 while `refresh_pending` is already 1, set `refresh_late` (sticky until reset).
  - `refresh_pending` clears in the ISSUE cycle of a refresh.
- Exactly one transaction is in flight at any time. Clients may present a new request from the cycle after their ack.

## Timing
- Reset values: all outputs 0; state IDLE; `refresh_pending=0`; `refresh_late=0`; timer at `REFRESH_CYCLES-1`.
- All outputs are registered. There is no combinational path from any input to any output.
- Request accepted in cycle N (IDLE, conditions met): ISSUE in N+1, `mc_busy` expected high from N+2.
- Read/write response: `*_valid` is high in the cycle after `mc_busy` is first sampled low in WAIT_DONE.
- Timer expiry in the same cycle as a client request: refresh wins.
- Expiry during a transaction: the refresh waits in pending and goes first at the next IDLE.
- Reset mid-transaction: return to IDLE on the next edge. No ack or valid is produced for the discarded transaction; all strobes are 0.
- `mc_initialized=0`: no strobes are issued; requests wait unacknowledged.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A and B alternate priority.
  - After a B grant A has priority, and after an A grant B has priority.
  - The initial priority after reset is A.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, B over A. A is served only when `b_req=0`.

## Test plan
- Reset, `mc_initialized=1`, A read of address 0x000010; controller model returns 0xDEADBEEF → `a_ack` in ISSUE, `mc_read_a=1` for one cycle with `mc_addr=0x000010`, `a_valid` with `a_rdata=0xDEADBEEF`.
- B write 0x12345678, mask 4'b0011, address 0x7FFFFF → `mc_write` pulse with matching `mc_din`/`mc_mask`/`mc_addr`, `b_valid` after `mc_busy` falls, `b_rdata` unchanged.
- `REFRESH_CYCLES=16`, no client traffic → `mc_refresh` pulse every 16 cycles, `refresh_late` stays 0.
- `a_req` and `b_req` held continuously → with `ARB_ROUND_ROBIN_EN` the grants alternate A,B,A,B; without it B is granted every time and A never is.
- `REFRESH_CYCLES=4`, model holds `mc_busy` for 10 cycles → `refresh_late=1`, and it stays set until reset.
- Assert `reset` in WAIT_DONE → all strobes 0, no `*_valid`, the next request is serviced normally.
